// File: rtl/vote_result_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : vote_result_uart_tx
// Brief    : Serialises a snapshot of four candidate tallies as one 8N1 UART
//            frame: header, four counts, 8-bit wrap checksum.
// Revision : 1.0 - initial release
// ============================================================================
module vote_result_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] cand1_vote,
  input  logic [7:0] cand2_vote,
  input  logic [7:0] cand3_vote,
  input  logic [7:0] cand4_vote,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BYTE = 3'd5;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_START_BIT = 2'd1;
  localparam logic [1:0] S_DATA_BITS = 2'd2;
  localparam logic [1:0] S_STOP_BIT  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [2:0]        byte_q, byte_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        snap1_q, snap2_q, snap3_q, snap4_q;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept;
  logic              baud_end;
  logic [2:0]        byte_nxt_idx;
  logic [7:0]        byte_nxt;
  logic [7:0]        checksum;

  assign accept       = start && (state_q == S_IDLE) && !busy_q;
  assign baud_end     = (baud_q == BAUD_LAST);
  assign byte_nxt_idx = byte_q + 3'd1;
  assign checksum     = snap1_q + snap2_q + snap3_q + snap4_q;

  // Byte loaded into the shift register when the next START_BIT begins.
  always_comb begin
    byte_nxt = HEADER;
    case (byte_nxt_idx)
      3'd1:    byte_nxt = snap1_q;
      3'd2:    byte_nxt = snap2_q;
      3'd3:    byte_nxt = snap3_q;
      3'd4:    byte_nxt = snap4_q;
      3'd5:    byte_nxt = checksum;
      default: byte_nxt = HEADER;
    endcase
  end

  // State register and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      snap1_q <= '0;
      snap2_q <= '0;
      snap3_q <= '0;
      snap4_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (accept) begin
        snap1_q <= cand1_vote;
        snap2_q <= cand2_vote;
        snap3_q <= cand3_vote;
        snap4_q <= cand4_vote;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (accept)                         state_d = S_START_BIT;
      S_START_BIT: if (baud_end)                       state_d = S_DATA_BITS;
      S_DATA_BITS: if (baud_end && (bit_q == 3'd7))    state_d = S_STOP_BIT;
      S_STOP_BIT:  if (baud_end)
                     state_d = (byte_q == LAST_BYTE) ? S_IDLE : S_START_BIT;
      default:                                         state_d = S_IDLE;
    endcase
  end

  // Counters and shift register
  always_comb begin
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;

    if (state_q == S_IDLE) begin
      baud_d = '0;
    end else if (baud_end) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + BAUD_W'(1);
    end

    if (state_q != S_DATA_BITS) begin
      bit_d = 3'd0;
    end else if (baud_end) begin
      bit_d = bit_q + 3'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          byte_d  = 3'd0;
          shift_d = HEADER;
        end
      end
      S_DATA_BITS: begin
        if (baud_end) shift_d = {1'b0, shift_q[7:1]};
      end
      S_STOP_BIT: begin
        if (baud_end) begin
          if (byte_q == LAST_BYTE) begin
            byte_d = 3'd0;
          end else begin
            byte_d  = byte_nxt_idx;
            shift_d = byte_nxt;
          end
        end
      end
      default: ;
    endcase
  end

  // Output logic: next values of the registered outputs, derived from the
  // upcoming state so tx changes on the same edge as the state.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_STOP_BIT) && baud_end && (byte_q == LAST_BYTE);
    case (state_d)
      S_IDLE:      tx_d = 1'b1;
      S_START_BIT: tx_d = 1'b0;
      S_DATA_BITS: tx_d = shift_d[0];
      S_STOP_BIT:  tx_d = 1'b1;
      default:     tx_d = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_vote_result_uart_tx.sv
`default_nettype none
// Testbench for vote_result_uart_tx: drives tallies and start pulses, compares
// the serial line cycle by cycle against a frame model built from byte values.
module tb_vote_result_uart_tx;

  localparam int N     = 4;
  localparam int FRAME = 60 * N;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] c1, c2, c3, c4;
  wire        tx, busy, done;

  int errors = 0;
  int checks = 0;

  logic obs_tx[$];
  logic obs_busy[$];
  logic obs_done[$];
  logic exp_tx[$];

  vote_result_uart_tx #(.CLKS_PER_BIT(N), .HEADER(8'hA5)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .cand1_vote (c1),
    .cand2_vote (c2),
    .cand3_vote (c3),
    .cand4_vote (c4),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] frame_byte(input int j, input int a, input int b,
                                            input int c, input int d);
    case (j)
      0:       return 8'hA5;
      1:       return a[7:0];
      2:       return b[7:0];
      3:       return c[7:0];
      4:       return d[7:0];
      default: return 8'((a + b + c + d) % 256);
    endcase
  endfunction

  // Line level for every cycle of a frame: 6 bytes, each start + 8 data LSB-first + stop.
  function automatic void build_frame(input int a, input int b, input int c, input int d);
    logic [7:0] by;
    logic       lvl;
    exp_tx.delete();
    for (int j = 0; j < 6; j++) begin
      by = frame_byte(j, a, b, c, d);
      for (int k = 0; k < 10; k++) begin
        if (k == 0)      lvl = 1'b0;
        else if (k == 9) lvl = 1'b1;
        else             lvl = by[k-1];
        for (int r = 0; r < N; r++) exp_tx.push_back(lvl);
      end
    end
  endfunction

  function automatic logic [7:0] decode_byte(input int base, input int j);
    logic [7:0] v;
    v = 8'h00;
    for (int k = 0; k < 8; k++) v[k] = obs_tx[base + (j * 10 + k + 1) * N + N / 2];
    return v;
  endfunction

  task automatic clear_obs();
    obs_tx.delete();
    obs_busy.delete();
    obs_done.delete();
  endtask

  task automatic sample_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      obs_tx.push_back(tx);
      obs_busy.push_back(busy);
      obs_done.push_back(done);
    end
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic set_counts(input int a, input int b, input int c, input int d);
    c1 = a[7:0]; c2 = b[7:0]; c3 = c[7:0]; c4 = d[7:0];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({tx, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_state tx/busy/done=%b expected 100", {tx, busy, done});
    end
    reset = 1'b0;
    clear_obs();
    sample_n(50);
    for (int i = 0; i < 50; i++) begin
      checks++;
      if ({obs_tx[i], obs_busy[i], obs_done[i]} !== 3'b100) begin
        errors++;
        $display("FAIL idle cyc=%0d tx/busy/done=%b expected 100", i,
                 {obs_tx[i], obs_busy[i], obs_done[i]});
      end
    end
  endtask

  task automatic test_frame_content();
    logic [7:0] got;
    logic [7:0] want;
    int nbusy, ndone;
    set_counts(3, 0, 255, 7);
    build_frame(3, 0, 255, 7);
    pulse_start();
    clear_obs();
    sample_n(FRAME + 10);
    for (int i = 0; i < FRAME; i++) begin
      checks++;
      if (obs_tx[i] !== exp_tx[i]) begin
        errors++;
        $display("FAIL content_tx cyc=%0d got %b expected %b", i, obs_tx[i], exp_tx[i]);
      end
    end
    for (int j = 0; j < 6; j++) begin
      got  = decode_byte(0, j);
      want = frame_byte(j, 3, 0, 255, 7);
      checks++;
      if (got !== want || obs_tx[j*10*N + N/2] !== 1'b0 || obs_tx[(j*10+9)*N + N/2] !== 1'b1) begin
        errors++;
        $display("FAIL content_byte%0d got %h start=%b stop=%b expected %h start=0 stop=1", j, got,
                 obs_tx[j*10*N + N/2], obs_tx[(j*10+9)*N + N/2], want);
      end
    end
    nbusy = 0;
    ndone = 0;
    for (int i = 0; i < FRAME + 10; i++) begin
      if (obs_busy[i] === 1'b1) nbusy++;
      if (obs_done[i] === 1'b1) ndone++;
    end
    checks++;
    if (nbusy != FRAME || ndone != 1 || obs_done[FRAME] !== 1'b1 || obs_busy[FRAME-1] !== 1'b1) begin
      errors++;
      $display("FAIL content_busy_done busy=%0d done=%0d done@end=%b expected busy=%0d done=1 done@end=1",
               nbusy, ndone, obs_done[FRAME], FRAME);
    end
  endtask

  task automatic test_bit_timing();
    logic [7:0] pat;
    int lowrun;
    pat = 8'hA5;
    set_counts($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 255));
    @(negedge clock);
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL timing_pre_idle tx=%b expected 1", tx);
    end
    pulse_start();
    clear_obs();
    sample_n(10 * N + 2);
    lowrun = 0;
    while (lowrun < 10 * N && obs_tx[lowrun] === 1'b0) lowrun++;
    checks++;
    if (obs_tx[0] !== 1'b0 || lowrun != N) begin
      errors++;
      $display("FAIL timing_start_bit first=%b low_len=%0d expected 0 and %0d", obs_tx[0], lowrun, N);
    end
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < N; r++) begin
        checks++;
        if (obs_tx[(k + 1) * N + r] !== pat[k]) begin
          errors++;
          $display("FAIL timing_data bit=%0d sub=%0d got %b expected %b", k, r,
                   obs_tx[(k + 1) * N + r], pat[k]);
        end
      end
    end
    sample_n(FRAME);
  endtask

  task automatic test_snapshot();
    int nbusy, ndone;
    set_counts(1, 2, 3, 4);
    build_frame(1, 2, 3, 4);
    pulse_start();
    clear_obs();
    for (int i = 0; i < FRAME + 20; i++) begin
      @(negedge clock);
      obs_tx.push_back(tx);
      obs_busy.push_back(busy);
      obs_done.push_back(done);
      if (i == 50)  set_counts(9, 9, 9, 9);
      if (i == 100) start = 1'b1;
      if (i == 101) start = 1'b0;
    end
    for (int i = 0; i < FRAME; i++) begin
      checks++;
      if (obs_tx[i] !== exp_tx[i]) begin
        errors++;
        $display("FAIL snapshot_tx cyc=%0d got %b expected %b", i, obs_tx[i], exp_tx[i]);
      end
    end
    checks++;
    if (decode_byte(0, 5) !== 8'h0A) begin
      errors++;
      $display("FAIL snapshot_checksum got %h expected 0a", decode_byte(0, 5));
    end
    nbusy = 0;
    ndone = 0;
    for (int i = 0; i < FRAME + 20; i++) begin
      if (obs_busy[i] === 1'b1) nbusy++;
      if (obs_done[i] === 1'b1) ndone++;
    end
    checks++;
    if (nbusy != FRAME || ndone != 1) begin
      errors++;
      $display("FAIL snapshot_single_frame busy=%0d done=%0d expected %0d and 1", nbusy, ndone, FRAME);
    end
  endtask

  task automatic test_reset_mid_frame();
    int a, b, c, d;
    set_counts($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 255));
    pulse_start();
    clear_obs();
    sample_n((2 * 10 + 3) * N + 1);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({tx, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL midreset_edge tx/busy/done=%b expected 100", {tx, busy, done});
    end
    reset = 1'b0;
    clear_obs();
    sample_n(3 * 10 * N);
    for (int i = 0; i < 3 * 10 * N; i++) begin
      checks++;
      if ({obs_tx[i], obs_busy[i], obs_done[i]} !== 3'b100) begin
        errors++;
        $display("FAIL midreset_after cyc=%0d tx/busy/done=%b expected 100", i,
                 {obs_tx[i], obs_busy[i], obs_done[i]});
      end
    end
    a = $urandom_range(0, 255); b = $urandom_range(0, 255);
    c = $urandom_range(0, 255); d = $urandom_range(0, 255);
    set_counts(a, b, c, d);
    build_frame(a, b, c, d);
    pulse_start();
    clear_obs();
    sample_n(FRAME + 2);
    for (int i = 0; i < FRAME + 2; i++) begin
      checks++;
      if (obs_tx[i] !== (i < FRAME ? exp_tx[i] : 1'b1) || obs_busy[i] !== (i < FRAME) ||
          obs_done[i] !== (i == FRAME)) begin
        errors++;
        $display("FAIL midreset_reframe cyc=%0d tx/busy/done=%b%b%b expected %b%b%b", i,
                 obs_tx[i], obs_busy[i], obs_done[i], (i < FRAME ? exp_tx[i] : 1'b1),
                 (i < FRAME), (i == FRAME));
      end
    end
  endtask

  task automatic test_back_to_back();
    int dpos[$];
    int k;
    logic et, eb, ed;
    set_counts(200, 100, 0, 0);
    build_frame(200, 100, 0, 0);
    @(negedge clock);
    start = 1'b1;
    clear_obs();
    // Start stays high through the first frame and its done cycle.
    for (int i = 0; i < 2 * FRAME + 6; i++) begin
      @(negedge clock);
      obs_tx.push_back(tx);
      obs_busy.push_back(busy);
      obs_done.push_back(done);
      if (i == FRAME + 1) start = 1'b0;
    end
    // Frame 1 at 0..FRAME-1, done/accept cycle at FRAME, frame 2 from FRAME+1.
    for (int i = 0; i < 2 * FRAME + 6; i++) begin
      if (i < FRAME) begin
        et = exp_tx[i]; eb = 1'b1; ed = 1'b0;
      end else if (i == FRAME || i == 2 * FRAME + 1) begin
        et = 1'b1; eb = 1'b0; ed = 1'b1;
      end else if (i <= 2 * FRAME) begin
        k = i - FRAME - 1;
        et = exp_tx[k]; eb = 1'b1; ed = 1'b0;
      end else begin
        et = 1'b1; eb = 1'b0; ed = 1'b0;
      end
      checks++;
      if (obs_tx[i] !== et || obs_busy[i] !== eb || obs_done[i] !== ed) begin
        errors++;
        $display("FAIL b2b cyc=%0d tx/busy/done=%b%b%b expected %b%b%b", i,
                 obs_tx[i], obs_busy[i], obs_done[i], et, eb, ed);
      end
      if (obs_done[i] === 1'b1) dpos.push_back(i);
    end
    checks++;
    if (decode_byte(FRAME + 1, 5) !== 8'h2C || decode_byte(0, 5) !== 8'h2C) begin
      errors++;
      $display("FAIL b2b_checksum got %h/%h expected 2c/2c", decode_byte(0, 5),
               decode_byte(FRAME + 1, 5));
    end
    checks++;
    if (dpos.size() != 2 || dpos[1] - dpos[0] != FRAME + 1) begin
      errors++;
      $display("FAIL b2b_done_spacing pulses=%0d expected 2 spaced %0d", dpos.size(), FRAME + 1);
    end
  endtask

  task automatic test_random();
    int a, b, c, d;
    for (int f = 0; f < 4; f++) begin
      a = $urandom_range(0, 255); b = $urandom_range(0, 255);
      c = $urandom_range(0, 255); d = $urandom_range(0, 255);
      set_counts(a, b, c, d);
      build_frame(a, b, c, d);
      repeat ($urandom_range(1, 5)) @(negedge clock);
      pulse_start();
      set_counts($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255));
      clear_obs();
      sample_n(FRAME + 2);
      for (int i = 0; i < FRAME + 2; i++) begin
        checks++;
        if (obs_tx[i] !== (i < FRAME ? exp_tx[i] : 1'b1) || obs_busy[i] !== (i < FRAME) ||
            obs_done[i] !== (i == FRAME)) begin
          errors++;
          $display("FAIL random f=%0d cyc=%0d tx/busy/done=%b%b%b expected %b%b%b", f, i,
                   obs_tx[i], obs_busy[i], obs_done[i], (i < FRAME ? exp_tx[i] : 1'b1),
                   (i < FRAME), (i == FRAME));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    set_counts(0, 0, 0, 0);
    test_reset();
    test_frame_content();
    test_bit_timing();
    test_snapshot();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
